cdb_arb: RTL
============

# cdb_arb

Parametrised common-data-bus arbiter for the out-of-order core. It sits between N execution units (ALU, MDU, LSU, and any added later) and the reservation stations, rename file and ROB. Each unit's results are buffered in a per-unit FIFO. Up to NUM_CDB results per cycle are granted round-robin onto NUM_CDB broadcast lanes. A single flush input discards everything in flight. It generalises the fixed three-input, single-lane bus to configurable channel count, lane count and buffering, with fairness and back-pressure.

## Interface
- N_EXU, default 3: number of execution-unit channels (2..8).
- NUM_CDB, default 1: number of broadcast lanes (1..N_EXU).
- FIFO_DEPTH, default 2: entries per channel FIFO (power of two, ≥2).
- TAG_W, default 4: reservation-station / ROB tag width.
- DATA_W, default 32: result width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- flush  in  1  pipeline flush (mispredict); discards all buffered and registered results.
- exu_valid  in  N_EXU  per-channel result valid.
- exu_ready  out  N_EXU  per-channel FIFO not full.
- exu_tag  in  N_EXU*TAG_W  result tag, channel i at bits [i*TAG_W +: TAG_W].
- exu_rd  in  N_EXU*5  destination architectural register.
- exu_data  in  N_EXU*DATA_W  result value.
- cdb_valid  out  NUM_CDB  lane valid (registered).
- cdb_tag  out  NUM_CDB*TAG_W  broadcast tag (registered).
- cdb_rd  out  NUM_CDB*5  broadcast rd (registered).
- cdb_data  out  NUM_CDB*DATA_W  broadcast value (registered).

## Operation
- Push: when exu_valid[i] && exu_ready[i] in a cycle, {tag, rd, data} is written to FIFO i. exu_ready[i] = (count[i] != FIFO_DEPTH) and is derived from registered count only. There is no same-cycle pop credit.
- Arbitration (combinational, each cycle):
  - Scan channels rr_ptr, rr_ptr+1, …, wrapping modulo N_EXU.
  - Grant the first NUM_CDB non-empty FIFOs.
  - Grant k drives lane k, with lane 0 taking the highest priority.
- Pop: each granted FIFO pops its head at the clock edge. Each popped entry loads its lane's output register with cdb_valid[k]=1. Lanes without a grant load cdb_valid[k]=0; their tag/rd/data hold their previous values.
- Round-robin update: if at least one grant, rr_ptr ← (last granted index + 1) mod N_EXU; otherwise rr_ptr holds.
- Push and pop on the same FIFO in the same cycle: count unchanged, order preserved.
- Flush (highest priority after reset):
  - All FIFO counts and pointers ← 0.
  - cdb_valid ← 0.
  - rr_ptr ← 0.
  - Any push offered in the flush cycle is dropped.
  - exu_ready is high again the next cycle.
- Reset (rst==0 at an edge): all FIFO counts ← 0; rr_ptr ← 0; cdb_valid/tag/rd/data ← 0.
- exu_ready is 0 while rst is low and goes high the cycle after rst deasserts. exu_ready is the only combinationally masked output.
- Reset or flush mid-burst discards every partially drained FIFO; no entry is broadcast afterward.

## Timing
- Latency: an accept in cycle t makes the entry the FIFO head in cycle t+1. If it is granted in t+1, cdb_valid is visible in t+2. The minimum push-to-broadcast latency is 2 cycles.
- Throughput: each lane sustains one result per cycle. Each channel sustains one result per cycle when it is granted every cycle.
- Starvation bound: with all channels continuously busy, a non-empty channel is granted within ceil(N_EXU/NUM_CDB) cycles.
- Back-pressure: with FIFO_DEPTH=2 and continuous denial, exu_ready[i] falls in the cycle after the second accept.
- No combinational path from exu_* to cdb_*. exu_ready depends only on registered state and rst.

## Structure
- Package cdb_pkg:
  - cdb_entry_t packed struct {tag, rd, data}, parametrised through a typedef in the module or localparams mirrored from TAG_W/DATA_W.
  - Helper function rr_next(idx, n).
- Sub-module cdb_fifo (synchronous FIFO of cdb_entry_t; ports push, pop, clr, full, empty, head), instantiated N_EXU times.
- The arbiter scan and the output registers live in cdb_arb.

## Test plan
- Single result: N_EXU=3, NUM_CDB=1; ch1 pushes tag=5, rd=7, data=0xDEADBEEF at t=10 -> cdb_valid=1 with those values at t=12 only; exu_ready stays 1.
- Fairness: all three channels push every cycle, NUM_CDB=1 -> grant order ch0,ch1,ch2,ch0,…; each exu_ready[i] drops after 2 un-granted accepts; no entry lost or reordered per channel.
- Dual lane: NUM_CDB=2, ch0 and ch2 push at t -> at t+2 lane0=ch0, lane1=ch2; rr_ptr=0 next, so the following ch0/ch1/ch2 burst grants ch0,ch1 then ch2.
- Flush: fill all FIFOs, assert flush for 1 cycle -> cdb_valid=0 from the next cycle; nothing broadcast afterward; exu_ready=all-ones the cycle after flush; a push offered in the flush cycle never appears.
- Reset mid-operation: rst low for 1 cycle while full -> all outputs 0 and exu_ready=0 while rst=0; exu_ready=1 the cycle after release; no stale broadcast.
- Full boundary: channel full while granted, exu_valid held -> ready low that cycle; after the pop, ready returns and a push plus a pop in the same cycle keeps count=2.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared constants and helpers for the common-data-bus arbiter.
package cdb_pkg;

   localparam int RD_W = 5;

   // Round-robin successor of a channel index, wrapping at n.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Synchronous FIFO holding one execution unit's pending CDB entries.
module cdb_fifo #(
   parameter int WIDTH = 41,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;

   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; count gates every read, so stale words are never observed.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

endmodule

// File: rtl/cdb_arb.sv
// Round-robin arbiter moving buffered execution-unit results onto NUM_CDB broadcast lanes.
module cdb_arb
   import cdb_pkg::*;
#(
   parameter int N_EXU      = 3,
   parameter int NUM_CDB    = 1,
   parameter int FIFO_DEPTH = 2,
   parameter int TAG_W      = 4,
   parameter int DATA_W     = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic [N_EXU-1:0]          exu_valid,
   output logic [N_EXU-1:0]          exu_ready,
   input  logic [N_EXU*TAG_W-1:0]    exu_tag,
   input  logic [N_EXU*RD_W-1:0]     exu_rd,
   input  logic [N_EXU*DATA_W-1:0]   exu_data,
   output logic [NUM_CDB-1:0]        cdb_valid,
   output logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
   output logic [NUM_CDB*RD_W-1:0]   cdb_rd,
   output logic [NUM_CDB*DATA_W-1:0] cdb_data
);

   localparam int PTR_W = $clog2(N_EXU);

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [RD_W-1:0]   rd;
      logic [DATA_W-1:0] data;
   } cdb_entry_t;

   localparam int ENTRY_W = $bits(cdb_entry_t);

   cdb_entry_t         heads [N_EXU];
   logic [N_EXU-1:0]   full;
   logic [N_EXU-1:0]   empty;
   logic [N_EXU-1:0]   push;
   logic [N_EXU-1:0]   pop;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   rr_new;
   logic [NUM_CDB-1:0] lane_gnt;
   logic [PTR_W-1:0]   lane_src [NUM_CDB];

   // Ready is masked by reset only; it never looks at this cycle's pops.
   assign exu_ready = rst ? ~full : '0;
   assign push      = exu_valid & exu_ready & {N_EXU{~flush}};

   for (genvar g = 0; g < N_EXU; g++) begin : g_ch
      cdb_entry_t din;
      assign din = {exu_tag[g*TAG_W +: TAG_W], exu_rd[g*RD_W +: RD_W], exu_data[g*DATA_W +: DATA_W]};

      cdb_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .clr   (flush),
         .push  (push[g]),
         .pop   (pop[g]),
         .din   (din),
         .full  (full[g]),
         .empty (empty[g]),
         .head  (heads[g])
      );
   end

   // Each lane in turn takes the first untaken non-empty channel in scan order from rr_ptr.
   always_comb begin
      logic [N_EXU-1:0] avail;
      logic [PTR_W-1:0] ch;
      int               chi;
      // NOTE: every output gets a default before the loops, so no path leaves a latch behind.
      avail  = ~empty;
      pop    = '0;
      lane_gnt = '0;
      rr_new = rr_ptr;
      for (int k = 0; k < NUM_CDB; k++) lane_src[k] = '0;
      for (int k = 0; k < NUM_CDB; k++) begin
         for (int j = 0; j < N_EXU; j++) begin
            chi = int'(rr_ptr) + j;
            if (chi >= N_EXU) chi = chi - N_EXU;
            ch = PTR_W'(chi);
            if (!lane_gnt[k] && avail[ch]) begin
               lane_gnt[k] = 1'b1;
               lane_src[k] = ch;
               avail[ch]   = 1'b0;
               pop[ch]     = 1'b1;
               rr_new      = PTR_W'(rr_next(chi, N_EXU));
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr    <= '0;
         cdb_valid <= '0;
         cdb_tag   <= '0;
         cdb_rd    <= '0;
         cdb_data  <= '0;
      end else if (flush) begin
         rr_ptr    <= '0;
         cdb_valid <= '0;
      end else begin
         rr_ptr <= rr_new;
         for (int k = 0; k < NUM_CDB; k++) begin
            cdb_valid[k] <= lane_gnt[k];
            // Idle lanes keep their last payload; only valid drops.
            if (lane_gnt[k]) begin
               cdb_tag[k*TAG_W +: TAG_W]    <= heads[lane_src[k]].tag;
               cdb_rd[k*RD_W +: RD_W]       <= heads[lane_src[k]].rd;
               cdb_data[k*DATA_W +: DATA_W] <= heads[lane_src[k]].data;
            end
         end
      end
   end

endmodule
